div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the integer ALU in the execute stage and is issued by the control unit. The HDU stalls the pipeline while `busy_o` is high. It retires one result per operation through a single-cycle `valid_o` pulse.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_unit_pkg;

  localparam int DATA_SIZE_DEF  = 32;
  localparam int DIV_ITERATIONS = 32;

  // funct3 bit positions used by the decoder; bit 2 carries no meaning here
  localparam int FUNCT_REM_BIT = 1;
  localparam int FUNCT_UNS_BIT = 0;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
//
// state    | meaning
// DIV_IDLE | waiting for start_i, busy_o low
// DIV_CALC | one shift/subtract step per cycle, 32 steps MSB first
// DIV_FIX  | sign correction of quotient/remainder, result registered
// DIV_DONE | valid_o pulse, result_o holds the new value
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           funct_i,
  input  logic [DATA_SIZE-1:0] op_a_i,
  input  logic [DATA_SIZE-1:0] op_b_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [DATA_SIZE-1:0] result_o
);

  localparam int CNT_W = $clog2(DIV_ITERATIONS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERATIONS - 1);

  div_state             state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_SIZE-1:0] prem_q;
  logic [DATA_SIZE-1:0] quo_q;
  logic [DATA_SIZE-1:0] dsr_q;
  logic [DATA_SIZE-1:0] result_q;
  logic                 sign_a_q;
  logic                 sign_b_q;
  logic                 is_rem_q;
  logic                 is_uns_q;

  logic                 sign_a_d;
  logic                 sign_b_d;
  logic [DATA_SIZE-1:0] mag_a_d;
  logic [DATA_SIZE-1:0] mag_b_d;
  logic [DATA_SIZE:0]   shifted;
  logic [DATA_SIZE:0]   diff;
  logic                 q_bit;
  logic [DATA_SIZE-1:0] prem_d;
  logic [DATA_SIZE-1:0] quo_d;
  logic [DATA_SIZE-1:0] quo_fix;
  logic [DATA_SIZE-1:0] rem_fix;
  logic [DATA_SIZE-1:0] result_d;
  logic                 unused_funct;

  assign unused_funct = funct_i[2];

  // 0x80000000 negates to itself, which read as unsigned is the correct magnitude 2^31
  always_comb begin
    sign_a_d = ~funct_i[FUNCT_UNS_BIT] & op_a_i[DATA_SIZE-1];
    sign_b_d = ~funct_i[FUNCT_UNS_BIT] & op_b_i[DATA_SIZE-1];
    mag_a_d  = sign_a_d ? -op_a_i : op_a_i;
    mag_b_d  = sign_b_d ? -op_b_i : op_b_i;
  end

  // Dividend bits shift out of quo_q while quotient bits shift in from the bottom
  always_comb begin
    shifted = {prem_q, quo_q[DATA_SIZE-1]};
    diff    = shifted - {1'b0, dsr_q};
    q_bit   = ~diff[DATA_SIZE];
    prem_d  = q_bit ? diff[DATA_SIZE-1:0] : shifted[DATA_SIZE-1:0];
    quo_d   = {quo_q[DATA_SIZE-2:0], q_bit};
  end

  always_comb begin
    quo_fix  = (~is_uns_q & (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    rem_fix  = (~is_uns_q & sign_a_q) ? -prem_q : prem_q;
    result_d = is_rem_q ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      prem_q   <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_rem_q <= 1'b0;
      is_uns_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            cnt_q    <= '0;
            prem_q   <= '0;
            quo_q    <= mag_a_d;
            dsr_q    <= mag_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_rem_q <= funct_i[FUNCT_REM_BIT];
            is_uns_q <= funct_i[FUNCT_UNS_BIT];
            if (op_b_i == '0) begin
              result_q <= funct_i[FUNCT_REM_BIT] ? op_a_i : '1;
              state_q  <= DIV_DONE;
            end else begin
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          prem_q <= prem_d;
          quo_q  <= quo_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          result_q <= result_d;
          state_q  <= DIV_DONE;
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state_q != DIV_IDLE);
  assign valid_o  = (state_q == DIV_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expectations queued at acceptance, checked on valid_o.
module tb_div_unit;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int          cyc;
  int          n_tot;
  int          n_bad;
  exp_t        sb[$];
  logic        prev_valid;
  logic [31:0] last_exp;

  div_unit #(.DATA_SIZE(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct_i  (funct_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      return f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return f[1] ? a % b : a / b;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid_o) begin
      chk("valid_gap", {31'b0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        chk("sb_empty", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        last_exp = e.res;
        chk("result", result_o, e.res);
        chk("valid_cyc", cyc, e.due);
      end
    end
    prev_valid = valid_o;
    if (rst || flush_i) begin
      sb.delete();
    end else if (start_i && !busy_o) begin
      e.res = ref_res(funct_i, op_a_i, op_b_i);
      e.due = cyc + ((op_b_i == 32'h0) ? 1 : 34);
      sb.push_back(e);
    end
  end

  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("timeout", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             output int t0);
    @(posedge clk);
    #1;
    funct_i = f;
    op_a_i  = a;
    op_b_i  = b;
    start_i = 1'b1;
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    int t0;
    int c;
    drive_start(f, a, b, t0);
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_idle(c);
    chk(tag, c - t0, (b == 32'h0) ? 32'd2 : 32'd35);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[$] = '{
    '{F_DIV,  32'h0000_0014, 32'hFFFF_FFFD},
    '{F_REM,  32'hFFFF_FFEC, 32'h0000_0003},
    '{F_DIVU, 32'hFFFF_FFEC, 32'h0000_0003},
    '{F_REMU, 32'hFFFF_FFEC, 32'h0000_0003},
    '{F_DIV,  32'h0000_0007, 32'h0000_0000},
    '{F_DIVU, 32'h0000_0007, 32'h0000_0000},
    '{F_REM,  32'h0000_0007, 32'h0000_0000},
    '{F_REM,  32'hFFFF_FFF9, 32'h0000_0000},
    '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF},
    '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF},
    '{3'b000, 32'hFFFF_FF9C, 32'h0000_0007},
    '{3'b011, 32'h8000_0000, 32'h8000_0000}
  };

  initial begin
    int t0;
    int c;
    logic [31:0] hold_exp;
    n_tot    = 0;
    n_bad    = 0;
    last_exp = 32'h0;
    rst      = 1'b1;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct_i  = 3'b0;
    op_a_i   = 32'h0;
    op_b_i   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {31'b0, busy_o},  32'd0);
    chk("rst_valid",  {31'b0, valid_o}, 32'd0);
    chk("rst_result", result_o,         32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) issue("idle_cyc", vecs[i].f, vecs[i].a, vecs[i].b);

    // flush in cycle 10 together with a new start held into cycle 11
    drive_start(F_DIV, 32'd100, 32'd7, t0);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    start_i = 1'b1;
    funct_i = F_DIVU;
    op_a_i  = 32'd1000;
    op_b_i  = 32'd10;
    @(negedge clk);
    chk("flush_cyc", cyc - t0, 32'd10);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle", {31'b0, busy_o}, 32'd0);
    chk("flush_res",  result_o,        last_exp);
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_idle(c);
    chk("flush_done", c - t0, 32'd46);

    // reset in cycle 20 of an operation
    drive_start(F_REM, 32'hDEAD_BEEF, 32'd13, t0);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_cyc",    cyc - t0,         32'd21);
    chk("rst2_busy",   {31'b0, busy_o},  32'd0);
    chk("rst2_valid",  {31'b0, valid_o}, 32'd0);
    chk("rst2_result", result_o,         32'd0);

    // back-to-back with start_i held high
    hold_exp = ref_res(F_DIV, 32'hFFFF_FC18, 32'd7);
    drive_start(F_DIV, 32'hFFFF_FC18, 32'd7, t0);
    @(posedge clk);
    #1;
    funct_i = F_REM;
    wait_idle(c);
    chk("b2b_acc", c - t0, 32'd35);
    @(posedge clk);
    #1 start_i = 1'b0;
    while (cyc < t0 + 50) @(negedge clk);
    chk("b2b_hold", result_o, hold_exp);
    wait_idle(c);
    chk("b2b_done", c - t0, 32'd70);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = (i == 3) ? 32'h8000_0000 : $urandom;
      case (i % 4)
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(31, 0);
      endcase
      issue("rnd_idle", 3'($urandom_range(7, 0)), a, b);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
